// File: rtl/mux_out_signature_pkg.sv
// Shared types and constants for the mux_out signature checker.
// Holds the run-state encoding, default MISR parameters and the MISR step.
package mux_out_signature_pkg;

    localparam int DEF_WIDTH = 20;
    localparam logic [DEF_WIDTH-1:0] DEF_POLY = 20'h00009;
    localparam logic [DEF_WIDTH-1:0] DEF_SEED = 20'hFFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // One MISR clock: shift left, fold the feedback taps on carry-out, xor in the sample.
    function automatic logic [DEF_WIDTH-1:0] misr_step(
        input logic [DEF_WIDTH-1:0] sig,
        input logic [DEF_WIDTH-1:0] data,
        input logic [DEF_WIDTH-1:0] poly
    );
        misr_step = {sig[DEF_WIDTH-2:0], 1'b0}
                  ^ (sig[DEF_WIDTH-1] ? poly : {DEF_WIDTH{1'b0}})
                  ^ data;
    endfunction

endpackage

// File: rtl/mux_out_signature_bus_sync.sv
// Per-bit multi-flop synchroniser for an asynchronous test vector.
// Bits are synchronised independently; no cross-bit coherence is implied.
module bus_sync #(
    parameter int WIDTH       = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_r [SYNC_STAGES];

    // Synchroniser chain, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/mux_out_signature.sv
// Resynchronises mux_out, folds a fixed window into a MISR and reports pass/fail.
// Optional toggle counter output enabled by MUX_OUT_SIGNATURE_TOGGLE_CNT_EN.
module mux_out_signature
    import mux_out_signature_pkg::*;
#(
    parameter int               WIDTH         = DEF_WIDTH,
    parameter int               SYNC_STAGES   = 2,
    parameter int               SETTLE_CYCLES = 4,
    parameter int               CAPTURE_LEN   = 256,
    parameter logic [WIDTH-1:0] POLY          = DEF_POLY,
    parameter logic [WIDTH-1:0] SEED          = DEF_SEED
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] expected,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
`ifdef MUX_OUT_SIGNATURE_TOGGLE_CNT_EN
    ,
    output logic [15:0]      toggle_cnt
`endif
);

    localparam int CNT_MAX = (SETTLE_CYCLES > CAPTURE_LEN) ? SETTLE_CYCLES : CAPTURE_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAPTURE_LAST = CNT_W'(CAPTURE_LEN - 1);

    state_t           state_r, state_next;
    logic [CNT_W-1:0] cnt_r, cnt_next;
    logic [WIDTH-1:0] signature_r, signature_next, misr_next;
    logic [WIDTH-1:0] din_s;
    logic             busy_r, done_r;

    bus_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .clr  (clr),
        .din  (din),
        .dout (din_s)
    );

    generate
        if (WIDTH == DEF_WIDTH) begin : g_pkg_misr
            assign misr_next = misr_step(signature_r, din_s, POLY);
        end else begin : g_local_misr
            assign misr_next = {signature_r[WIDTH-2:0], 1'b0}
                             ^ (signature_r[WIDTH-1] ? POLY : {WIDTH{1'b0}})
                             ^ din_s;
        end
    endgenerate

    // Run sequencing: start is only honoured from IDLE or DONE, so it never queues.
    always_comb begin
        state_next     = state_r;
        cnt_next       = cnt_r;
        signature_next = signature_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_next     = SETTLE;
                    cnt_next       = {CNT_W{1'b0}};
                    signature_next = SEED;
                end else begin
                    state_next = state_r;
                end
            end
            SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_next = CAPTURE;
                    cnt_next   = {CNT_W{1'b0}};
                end else begin
                    cnt_next = cnt_r + CNT_W'(1);
                end
            end
            CAPTURE: begin
                signature_next = misr_next;
                if (cnt_r == CAPTURE_LAST) begin
                    state_next = DONE;
                    cnt_next   = {CNT_W{1'b0}};
                end else begin
                    cnt_next = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, signature and status flags; clr abandons any run in progress.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            signature_r <= SEED;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next;
            cnt_r       <= cnt_next;
            signature_r <= signature_next;
            busy_r      <= (state_next == SETTLE) || (state_next == CAPTURE);
            done_r      <= (state_next == DONE);
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign signature = signature_r;
    assign pass      = done_r & (signature_r == expected);

`ifdef MUX_OUT_SIGNATURE_TOGGLE_CNT_EN
    logic [WIDTH-1:0] din_prev_r;
    logic [15:0]      toggle_r;
    logic [16:0]      toggle_sum;

    assign toggle_sum = {1'b0, toggle_r} + 17'($countones(din_s ^ din_prev_r));

    // Toggle activity during CAPTURE; the previous sample tracks every cycle so the
    // first capture comparison already has a valid reference.
    always_ff @(posedge clk) begin
        if (clr) begin
            din_prev_r <= {WIDTH{1'b0}};
            toggle_r   <= 16'h0000;
        end else begin
            din_prev_r <= din_s;
            if ((state_next == SETTLE) && (state_r != SETTLE)) begin
                toggle_r <= 16'h0000;
            end else if (state_r == CAPTURE) begin
                toggle_r <= toggle_sum[16] ? 16'hFFFF : toggle_sum[15:0];
            end else begin
                toggle_r <= toggle_r;
            end
        end
    end

    assign toggle_cnt = toggle_r;
`endif

endmodule

// File: tb/tb_mux_out_signature.sv
// Bench for mux_out_signature: four parameterisations share one stimulus stream and
// are checked every cycle against a run-level behavioural model plus literal expectations.
module tb_mux_out_signature;
    import mux_out_signature_pkg::*;

    localparam int NI     = 4;
    localparam int SETTLE = 4;
    localparam int SYNC   = 2;

    logic        clk = 1'b0;
    logic        clr, start;
    logic [19:0] din, expected;

    logic        busy_w [NI];
    logic        done_w [NI];
    logic        pass_w [NI];
    logic [19:0] sig_w  [NI];
    logic [15:0] tog_w  [NI];

    int          cap_len [NI] = '{8, 8, 1, 1};
    logic [19:0] seed_v  [NI] = '{20'hFFFFF, 20'h00000, 20'h00001, 20'h80000};

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    mux_out_signature #(.SETTLE_CYCLES(SETTLE), .CAPTURE_LEN(8), .SEED(20'hFFFFF)) u_main (
        .clk(clk), .clr(clr), .start(start), .din(din), .expected(expected),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .signature(sig_w[0])
`ifdef MUX_OUT_SIGNATURE_TOGGLE_CNT_EN
        , .toggle_cnt(tog_w[0])
`endif
    );
    mux_out_signature #(.SETTLE_CYCLES(SETTLE), .CAPTURE_LEN(8), .SEED(20'h00000)) u_zero (
        .clk(clk), .clr(clr), .start(start), .din(din), .expected(expected),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .signature(sig_w[1])
`ifdef MUX_OUT_SIGNATURE_TOGGLE_CNT_EN
        , .toggle_cnt(tog_w[1])
`endif
    );
    mux_out_signature #(.SETTLE_CYCLES(SETTLE), .CAPTURE_LEN(1), .SEED(20'h00001)) u_s1 (
        .clk(clk), .clr(clr), .start(start), .din(din), .expected(expected),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .signature(sig_w[2])
`ifdef MUX_OUT_SIGNATURE_TOGGLE_CNT_EN
        , .toggle_cnt(tog_w[2])
`endif
    );
    mux_out_signature #(.SETTLE_CYCLES(SETTLE), .CAPTURE_LEN(1), .SEED(20'h80000)) u_s8 (
        .clk(clk), .clr(clr), .start(start), .din(din), .expected(expected),
        .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .signature(sig_w[3])
`ifdef MUX_OUT_SIGNATURE_TOGGLE_CNT_EN
        , .toggle_cnt(tog_w[3])
`endif
    );

`ifndef MUX_OUT_SIGNATURE_TOGGLE_CNT_EN
    initial for (int i = 0; i < NI; i++) tog_w[i] = 16'h0000;
`endif

    // Behavioural model: a run is "age" edges old; the first SETTLE edges only wait,
    // the next cap_len edges fold the resynchronised sample, then the run is done.
    logic        m_active [NI];
    logic        m_done   [NI];
    int          m_age    [NI];
    logic [19:0] m_sig    [NI];
    int          m_tog    [NI];
    logic [19:0] dly      [SYNC];
    logic [19:0] m_prev;
    logic [19:0] ds_m;

    assign ds_m = dly[SYNC-1];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (clr) begin
                m_active[i] <= 1'b0;
                m_done[i]   <= 1'b0;
                m_age[i]    <= 0;
                m_sig[i]    <= seed_v[i];
                m_tog[i]    <= 0;
            end else if (m_active[i]) begin
                if (m_age[i] >= SETTLE) begin
                    m_sig[i] <= misr_step(m_sig[i], ds_m, DEF_POLY);
                    m_tog[i] <= (m_tog[i] + $countones(ds_m ^ m_prev) > 65535) ?
                                65535 : m_tog[i] + $countones(ds_m ^ m_prev);
                end
                m_age[i] <= m_age[i] + 1;
                if (m_age[i] + 1 == SETTLE + cap_len[i]) begin
                    m_active[i] <= 1'b0;
                    m_done[i]   <= 1'b1;
                end
            end else if (start) begin
                m_active[i] <= 1'b1;
                m_done[i]   <= 1'b0;
                m_age[i]    <= 0;
                m_sig[i]    <= seed_v[i];
                m_tog[i]    <= 0;
            end
        end
        m_prev <= clr ? 20'h00000 : ds_m;
        dly[0] <= clr ? 20'h00000 : din;
        for (int k = 1; k < SYNC; k++) dly[k] <= clr ? 20'h00000 : dly[k-1];
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, idx, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every instance against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk("busy", i, 32'(busy_w[i]), 32'(m_active[i]));
                chk("done", i, 32'(done_w[i]), 32'(m_done[i]));
                chk("pass", i, 32'(pass_w[i]), 32'(m_done[i] && (m_sig[i] == expected)));
                chk("signature", i, 32'(sig_w[i]), 32'(m_sig[i]));
`ifdef MUX_OUT_SIGNATURE_TOGGLE_CNT_EN
                chk("toggle_cnt", i, 32'(tog_w[i]), 32'(m_tog[i]));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise start, count edges until u_zero reports done; optionally re-pulse start
    // at edge pulse_at, hold it throughout, or alternate din every cycle.
    task automatic run(input int pulse_at, input bit hold, input bit alt, output int lat);
        start = 1'b1;
        lat   = 0;
        while (lat < 400) begin
            tick();
            lat++;
            start = hold || (lat == pulse_at);
            if (alt) din = ~din;
            if (done_w[1]) break;
        end
        if (!done_w[1]) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_timeout: done not seen after %0d cycles, expected within 400", lat);
        end
    endtask

    int lat;
    int done_seen;

    initial begin
        clr = 1'b1; start = 1'b0; din = 20'h00000; expected = 20'h00000;
        tick();
        chk_en = 1'b1;
        tick();
        clr = 1'b0;

        // Reset then idle
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_sig", 0, 32'(sig_w[0]), 32'h000FFFFF);
            chk("idle_busy_done_pass", 0, {29'd0, busy_w[0], done_w[0], pass_w[0]}, 32'h0);
        end

        // Zero vector and single-step arithmetic with din=0
        run(0, 1'b0, 1'b0, lat);
        chk("latency_zero", 1, lat, 13);
        chk("zero_sig", 1, 32'(sig_w[1]), 32'h0);
        chk("zero_pass", 1, 32'(pass_w[1]), 32'h1);
        chk("step_seed1_din0", 2, 32'(sig_w[2]), 32'h00002);
        chk("step_msb_din0", 3, 32'(sig_w[3]), 32'h00009);

        // Single step with din=1
        din = 20'h00001;
        repeat (3) tick();
        run(0, 1'b0, 1'b0, lat);
        chk("step_seed1_din1", 2, 32'(sig_w[2]), 32'h00003);

        // Mismatch: signature and done held while idle in DONE
        din = 20'h00000; expected = 20'h00001;
        repeat (3) tick();
        run(0, 1'b0, 1'b0, lat);
        chk("mismatch_pass", 1, 32'(pass_w[1]), 32'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("mismatch_hold_sig", 1, 32'(sig_w[1]), 32'h0);
            chk("mismatch_hold_done", 1, 32'(done_w[1]), 32'h1);
        end
        expected = 20'h00000;

        // Start pulse during CAPTURE is ignored
        run(6, 1'b0, 1'b0, lat);
        chk("latency_pulse_in_capture", 1, lat, 13);

        // Start held high: one run, then restart on the first DONE cycle
        run(0, 1'b1, 1'b0, lat);
        chk("latency_held_start", 1, lat, 13);
        tick();
        start = 1'b0;
        chk("held_restart_busy", 1, 32'(busy_w[1]), 32'h1);
        chk("held_restart_done", 1, 32'(done_w[1]), 32'h0);
        repeat (14) tick();
        chk("held_second_done", 1, 32'(done_w[1]), 32'h1);

        // Reset in the third CAPTURE cycle abandons the run
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("midrun_busy", 1, 32'(busy_w[1]), 32'h0);
        chk("midrun_seed_main", 0, 32'(sig_w[0]), 32'h000FFFFF);
        chk("midrun_seed_zero", 1, 32'(sig_w[1]), 32'h0);
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            done_seen += int'(done_w[0]) + int'(done_w[1]);
        end
        chk("midrun_no_done", 1, done_seen, 0);

        // Alternating input: every capture sample toggles all 20 bits
        din = 20'h00000;
        run(0, 1'b0, 1'b1, lat);
        chk("latency_alt", 1, lat, 13);
`ifdef MUX_OUT_SIGNATURE_TOGGLE_CNT_EN
        chk("toggle_alt", 1, 32'(tog_w[1]), 32'd160);
        chk("toggle_alt", 0, 32'(tog_w[0]), 32'd160);
`endif
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
